score_keeper: RTL

- Parametrised, registered successor to the per-hit score increment logic.
- Accepts one judgement per cycle from the note-judging logic: miss, good or perfect.
- Maintains a saturating score, a current combo, the best combo and a combo-driven point multiplier.
- Outputs feed the seven-segment/VGA score display and the end-of-song summary.

---
 rtl/score_keeper.sv | 122 ++++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// Registered score/combo/multiplier tracker fed by the note judge.
// One judgement per cycle; all outputs update on the edge that accepts it.
module score_keeper #(
  parameter int unsigned SCORE_W     = 16,
  parameter int unsigned COMBO_W     = 8,
  parameter int unsigned PERFECT_PTS = 3,
  parameter int unsigned GOOD_PTS    = 1,
  parameter int unsigned MULT_STEP   = 10,
  parameter int unsigned MAX_MULT    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               hold,
  input  logic               judge_valid,
  input  logic [1:0]         judge,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic [COMBO_W-1:0] max_combo,
  output logic [2:0]         mult,
  output logic               sat,
  output logic               upd_valid
);

  localparam int unsigned SUM_W  = SCORE_W + 4;
  localparam int unsigned STEP_W = (MULT_STEP > 1) ? $clog2(MULT_STEP) : 1;

  localparam logic [1:0] JUDGE_MISS    = 2'b00;
  localparam logic [1:0] JUDGE_PERFECT = 2'b10;
  localparam logic [1:0] JUDGE_RSVD    = 2'b11;

  typedef enum logic {RUN, HOLD} stateT;

  stateT              state, stateNext;
  logic [STEP_W-1:0]  stepCnt, stepCntNext;
  logic [SCORE_W-1:0] scoreNext;
  logic [COMBO_W-1:0] comboNext, maxComboNext;
  logic [2:0]         multNext;
  logic               satNext, updValidNext;

  logic [SUM_W-1:0]   basePts, points, sum;

  // Hit arithmetic is widened so the saturation compare cannot wrap.
  always_comb begin
    basePts = (judge == JUDGE_PERFECT) ? SUM_W'(PERFECT_PTS) : SUM_W'(GOOD_PTS);
    points  = basePts * SUM_W'(mult);
    sum     = SUM_W'(score) + points;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      score     <= '0;
      combo     <= '0;
      max_combo <= '0;
      mult      <= 3'd1;
      sat       <= 1'b0;
      upd_valid <= 1'b0;
      stepCnt   <= '0;
    end else begin
      state     <= stateNext;
      score     <= scoreNext;
      combo     <= comboNext;
      max_combo <= maxComboNext;
      mult      <= multNext;
      sat       <= satNext;
      upd_valid <= updValidNext;
      stepCnt   <= stepCntNext;
    end
  end

  // Next-state: clr beats hold beats judgement; HOLD drops every judgement.
  always_comb begin
    stateNext    = state;
    scoreNext    = score;
    comboNext    = combo;
    maxComboNext = max_combo;
    multNext     = mult;
    satNext      = sat;
    updValidNext = 1'b0;
    stepCntNext  = stepCnt;

    if (clr) begin
      stateNext    = RUN;
      scoreNext    = '0;
      comboNext    = '0;
      maxComboNext = '0;
      multNext     = 3'd1;
      satNext      = 1'b0;
      stepCntNext  = '0;
    end else if (hold) begin
      stateNext = HOLD;
    end else if (state == HOLD) begin
      stateNext = RUN;
    end else if (judge_valid && (judge != JUDGE_RSVD)) begin
      updValidNext = 1'b1;
      if (judge == JUDGE_MISS) begin
        comboNext   = '0;
        stepCntNext = '0;
        multNext    = 3'd1;
      end else begin
        if (|sum[SUM_W-1:SCORE_W]) begin
          scoreNext = '1;
          satNext   = 1'b1;
        end else begin
          scoreNext = sum[SCORE_W-1:0];
        end

        if (combo != '1) comboNext = combo + COMBO_W'(1);
        if (comboNext > max_combo) maxComboNext = comboNext;

        if (stepCnt == STEP_W'(MULT_STEP - 1)) begin
          stepCntNext = '0;
          if (mult < 3'(MAX_MULT)) multNext = mult + 3'd1;
        end else begin
          stepCntNext = stepCnt + STEP_W'(1);
        end
      end
    end
  end

endmodule
